// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between N bus masters and the rr_grant_arbiter.
// master = requester side, slave = arbiter side.
interface rr_grant_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic             prio_mode;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        output prio_mode,
        input  grant,
        input  grant_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  prio_mode,
        output grant,
        output grant_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// N-channel grant arbiter: round-robin or fixed priority, owner holds while requesting.
// Optional forced release after MAX_HOLD cycles when HOLD_TIMEOUT_EN is defined.
module rr_grant_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst,
    rr_grant_arbiter_if.slave   bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam bit CFG_OK = (N_REQ >= 2) && (MAX_HOLD >= 1);

    generate
        if (!CFG_OK) begin : g_illegal_cfg
            $error("rr_grant_arbiter: N_REQ must be >= 2 and MAX_HOLD >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic [ID_W-1:0]  grant_id_reg, grant_id_next;
    logic             busy_reg, busy_next;
    logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] win_onehot;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  scan_idx;
    logic             win_found;
    logic             owner_req;
    logic             hold_hit;

    assign owner_req = bus.req[grant_id_reg];

`ifdef HOLD_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              to_valid_reg, to_valid_next;
    logic              timeout_reg;
    logic [N_REQ-1:0]  to_mask;

    // While idle, grant_id still names the channel that timed out.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_to_mask
            assign to_mask[gi] = to_valid_reg && (grant_id_reg == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        hold_hit      = (state_reg == GRANT) && owner_req &&
                        (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
        hold_cnt_next = hold_cnt_reg;
        to_valid_next = to_valid_reg;
        if (state_reg == IDLE && win_found) begin
            hold_cnt_next = '0;
            to_valid_next = 1'b0;
        end else if (hold_hit) begin
            to_valid_next = 1'b1;
        end else if (state_reg == GRANT && owner_req) begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_reg <= '0;
            to_valid_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            to_valid_reg <= to_valid_next;
            timeout_reg  <= hold_hit;
        end
    end

    // The timed-out channel only yields if someone else is actually asking.
    always_comb begin
        cand = bus.req;
        if ((bus.req & ~to_mask) != '0) begin
            cand = bus.req & ~to_mask;
        end
    end

    assign bus.timeout = timeout_reg;
`else
    assign hold_hit    = 1'b0;
    assign cand        = bus.req;
    assign bus.timeout = 1'b0;
`endif

    // Winner search: fixed scans from 0, round-robin scans from rr_ptr with wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = bus.prio_mode ? ID_W'(i)
                                     : ID_W'((int'(rr_ptr_reg) + i) % N_REQ);
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    genvar gj;
    generate
        for (gj = 0; gj < N_REQ; gj++) begin : g_win_onehot
            assign win_onehot[gj] = (win_id == ID_W'(gj));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            grant_id_reg <= '0;
            busy_reg     <= 1'b0;
            rr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            grant_id_reg <= grant_id_next;
            busy_reg     <= busy_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_found) state_next = GRANT;
            GRANT:   if (!owner_req || hold_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_next    = grant_reg;
        grant_id_next = grant_id_reg;
        rr_ptr_next   = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    grant_next    = win_onehot;
                    grant_id_next = win_id;
                    rr_ptr_next   = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
                end
            end
            GRANT: begin
                if (state_next == IDLE) grant_next = '0;
            end
            default: grant_next = '0;
        endcase
        busy_next = |grant_next;
    end

    assign bus.grant    = grant_reg;
    assign bus.grant_id = grant_id_reg;
    assign bus.busy     = busy_reg;

endmodule
